// File: rtl/pacman_clk_pkg.sv
// Shared encoding and sizing helpers for the Pac-Man clock/reset sequencer.
package pacman_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  // Counter width for a modulus n; a 1-bit counter is kept even when n==1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pacman_sync_ff.sv
// N-stage synchroniser for a single asynchronous bit; latency N clk, no backpressure.
module pacman_sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[N-2:0], d};
  end

  assign q = chain[N-1];

endmodule

// File: rtl/pacman_clk_rst_seq.sv
// PLL-lock driven core reset stretcher plus pixel/CPU clock-enable dividers.
// core_reset releases SYNC_STAGES+LOCK_FILTER+HOLD_CYCLES edges after lock; no backpressure.
module pacman_clk_rst_seq
  import pacman_clk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 1024,
  parameter int PIX_DIV     = 4,
  parameter int CPU_DIV     = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pll_lock,
  output logic core_reset,
  output logic ready,
  output logic ce_pix,
  output logic ce_cpu
);

  localparam int FW = cnt_width(LOCK_FILTER);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int PW = cnt_width(PIX_DIV);
  localparam int CW = cnt_width(CPU_DIV);

  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(PIX_DIV - 1);
  localparam logic [CW-1:0] CPU_LAST  = CW'(CPU_DIV - 1);

  logic          lock_s;
  seq_state_t    state, state_nx;
  logic [FW-1:0] filt_cnt, filt_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [PW-1:0] pix_cnt;
  logic [CW-1:0] cpu_cnt;
  logic          in_wait;
  logic          pix_wrap;

  pacman_sync_ff #(.N(SYNC_STAGES)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_lock),
    .q       (lock_s)
  );

  always_comb begin
    state_nx = state;
    filt_nx  = filt_cnt;
    hold_nx  = hold_cnt;
    case (state)
      WAIT_LOCK: begin
        if (!lock_s) begin
          filt_nx = '0;
        end else if (filt_cnt == FILT_LAST) begin
          state_nx = HOLD;
          hold_nx  = '0;
        end else begin
          filt_nx = filt_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
          filt_nx  = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = RUN;
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
          filt_nx  = '0;
        end
      end
      default: begin
        state_nx = WAIT_LOCK;
        filt_nx  = '0;
      end
    endcase
  end

  // Dividers key off the next state so a drop to WAIT_LOCK suppresses a coincident wrap.
  assign in_wait  = (state_nx == WAIT_LOCK);
  assign pix_wrap = !in_wait && (pix_cnt == PIX_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_LOCK;
      filt_cnt   <= '0;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
      ready      <= 1'b0;
    end else begin
      state      <= state_nx;
      filt_cnt   <= filt_nx;
      hold_cnt   <= hold_nx;
      core_reset <= (state_nx != RUN);
      ready      <= (state_nx == RUN);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt <= '0;
      cpu_cnt <= '0;
      ce_pix  <= 1'b0;
      ce_cpu  <= 1'b0;
    end else if (in_wait) begin
      pix_cnt <= '0;
      cpu_cnt <= '0;
      ce_pix  <= 1'b0;
      ce_cpu  <= 1'b0;
    end else begin
      pix_cnt <= pix_wrap ? '0 : pix_cnt + 1'b1;
      ce_pix  <= pix_wrap;
      ce_cpu  <= pix_wrap && (cpu_cnt == CPU_LAST);
      if (pix_wrap) cpu_cnt <= (cpu_cnt == CPU_LAST) ? '0 : cpu_cnt + 1'b1;
    end
  end

endmodule
